// File: rtl/fetch_decode_queue_pkg.sv
// rtl/fetch_decode_queue_pkg.sv - shared types and halt-pattern constants for the fetch/decode queue
package fetch_decode_queue_pkg;

  typedef enum logic [1:0] {
    DQ_RUN       = 2'd0,
    DQ_HALT_SEEN = 2'd1,
    DQ_HALTED    = 2'd2
  } dq_state_t;

  localparam logic [31:0] HLT_MASK  = 32'hFFE0_001F;
  localparam logic [31:0] HLT_MATCH = 32'hD440_0000;

  localparam int DQ_INSN_BITS = 32;
  localparam int DQ_PC_BITS   = 64;

  typedef struct packed {
    logic [DQ_INSN_BITS-1:0] insnbits;
    logic [DQ_PC_BITS-1:0]   pc;
  } dq_entry_t;

  function automatic logic is_hlt(input logic [31:0] word);
    return (word & HLT_MASK) == HLT_MATCH;
  endfunction

endpackage

// File: rtl/fetch_decode_queue_dq_ptr_ctl.sv
// rtl/fetch_decode_queue_dq_ptr_ctl.sv - head/tail/count registers for the circular queue
module dq_ptr_ctl #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          in_clk,
  input  logic          in_rst_n,
  input  logic          in_enq,
  input  logic          in_deq,
  input  logic          in_flush,
  output logic [AW-1:0] out_head,
  output logic [AW-1:0] out_tail,
  output logic [AW:0]   out_count
);

  // DEPTH is a power of two, so pointer wrap is plain overflow
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_head  <= '0;
      out_tail  <= '0;
      out_count <= '0;
    end else if (in_flush) begin
      out_head  <= '0;
      out_tail  <= '0;
      out_count <= '0;
    end else begin
      if (in_enq) out_tail <= out_tail + 1'b1;
      if (in_deq) out_head <= out_head + 1'b1;
      if (in_enq && !in_deq)      out_count <= out_count + 1'b1;
      else if (!in_enq && in_deq) out_count <= out_count - 1'b1;
    end
  end

endmodule

// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - DEPTH-entry instruction queue between fetch and decode with flush and halt tracking
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int INSN_BITS = 32,
  parameter int PC_BITS   = 64
) (
  input  logic                       in_clk,
  input  logic                       in_rst_n,
  input  logic [INSN_BITS-1:0]       in_fetch_insnbits,
  input  logic [PC_BITS-1:0]         in_fetch_pc,
  input  logic                       in_fetch_done,
  output logic                       out_fetch_ready,
  input  logic                       in_stall,
  input  logic                       in_flush,
  output logic [INSN_BITS-1:0]       out_insnbits,
  output logic [PC_BITS-1:0]         out_pc,
  output logic                       out_done,
  output logic [$clog2(DEPTH):0]     out_count,
  output logic                       out_full,
  output logic                       out_empty,
  output logic                       out_halted
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0]        head;
  logic [AW-1:0]        tail;
  logic [AW:0]          count;
  logic                 enq;
  logic                 deq;
  dq_state_t            state;
  logic [INSN_BITS-1:0] insn_mem [DEPTH];
  logic [PC_BITS-1:0]   pc_mem   [DEPTH];

  assign out_count       = count;
  assign out_empty       = (count == '0);
  assign out_full        = (count == FULL_COUNT);
  assign out_halted      = (state == DQ_HALTED);
  assign out_done        = !out_empty && !out_halted;
  assign out_fetch_ready = !out_full && (state == DQ_RUN) && !in_flush;
  assign enq             = in_fetch_done && out_fetch_ready;
  assign deq             = out_done && !in_stall;
  assign out_insnbits    = out_done ? insn_mem[head] : '0;
  assign out_pc          = out_done ? pc_mem[head]   : '0;

  dq_ptr_ctl #(.DEPTH(DEPTH), .AW(AW)) u_ptr_ctl (
    .in_clk    (in_clk),
    .in_rst_n  (in_rst_n),
    .in_enq    (enq),
    .in_deq    (deq),
    .in_flush  (in_flush),
    .out_head  (head),
    .out_tail  (tail),
    .out_count (count)
  );

  // Storage is deliberately left out of reset; only the pointers define validity
  always_ff @(posedge in_clk) begin
    if (enq) begin
      insn_mem[tail] <= in_fetch_insnbits;
      pc_mem[tail]   <= in_fetch_pc;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state <= DQ_RUN;
    end else begin
      case (state)
        DQ_RUN:
          if (enq && is_hlt(in_fetch_insnbits[31:0])) state <= DQ_HALT_SEEN;
        DQ_HALT_SEEN:
          if (in_flush) state <= DQ_RUN;
          else if (deq && is_hlt(insn_mem[head][31:0])) state <= DQ_HALTED;
        default:
          state <= DQ_HALTED;
      endcase
    end
  end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
Parametrised instruction queue between fetch and decode/dispatch. It replaces the single-entry latch on the decode input with a DEPTH-entry circular FIFO carrying instruction bits and PC. It adds valid/ready backpressure toward fetch, a speculative flush, occupancy reporting, and halt tracking, so fetch can run ahead while dispatch stalls.

Parameters:
DEPTH, 8, number of queue entries; power of two, >= 2
INSN_BITS, 32, instruction word width (matches INSNBITS_SIZE)
PC_BITS, 64, program counter width

Ports:
in_clk  input  1  clock; all state updates on posedge
in_rst_n  input  1  asynchronous active-low reset
in_fetch_insnbits  input  INSN_BITS  instruction from fetch
in_fetch_pc  input  PC_BITS  PC of that instruction
in_fetch_done  input  1  fetch valid
out_fetch_ready  output  1  queue accepts an entry this cycle
in_stall  input  1  downstream (decode/dispatch) cannot consume this cycle
in_flush  input  1  discard all queued entries (mispredict/redirect)
out_insnbits  output  INSN_BITS  head entry instruction
out_pc  output  PC_BITS  head entry PC
out_done  output  1  head entry valid
out_count  output  $clog2(DEPTH)+1  current occupancy
out_full  output  1  count == DEPTH
out_empty  output  1  count == 0
out_halted  output  1  HLT has been dequeued; sticky

Behaviour:
- Reset (async, in_rst_n=0): head/tail pointers 0, count 0, state RUN. Outputs: out_done=0, out_empty=1, out_full=0, out_count=0, out_fetch_ready=1, out_halted=0, out_insnbits=0, out_pc=0. Entry storage is not cleared. Reset asserted mid-operation discards everything immediately, without waiting for a clock edge.
- Enqueue fires when in_fetch_done && out_fetch_ready. It writes {insnbits, pc} at tail; tail wraps modulo DEPTH.
- Dequeue fires when out_done && !in_stall. Head advances and wraps modulo DEPTH.
- out_done = !out_empty. out_insnbits/out_pc come from the head entry (registered storage, no combinational path from in_fetch_*). Head values are 0 when empty.
- Latency: an entry enqueued at edge N is visible on out_* after edge N. There is no same-cycle bypass when empty.
- out_fetch_ready = !out_full && state==RUN && !in_flush. It does not depend on a same-cycle dequeue.
- Simultaneous enqueue+dequeue: count unchanged; both pointers advance. When count==1, the head moves to the newly written entry.
- in_flush: synchronous with priority over enqueue/dequeue. Next edge: count 0, pointers 0, any enqueue/dequeue that cycle is dropped. State HALT_SEEN -> RUN. HALTED is unaffected.
- HLT detection: an enqueued word matches when bits[31:21]==11010100010 and bits[4:0]==00000.
- State machine (2-bit enum):
  RUN: enqueue of an HLT word -> HALT_SEEN.
  HALT_SEEN: no further enqueues. Dequeue of an entry matching HLT -> HALTED. Flush -> RUN.
  HALTED: out_halted=1, out_fetch_ready=0, no further dequeues (out_done=0). Left only by reset.
- out_count arithmetic: +1 on enqueue-only, -1 on dequeue-only. Never exceeds DEPTH or goes below 0. Enqueue when full is impossible by construction. The bench asserts that no dequeue occurs when empty.

Decomposition:
- Shared package data_structures.sv: new typedef dq_state_t {DQ_RUN, DQ_HALT_SEEN, DQ_HALTED}; constants HLT_MASK/HLT_MATCH for the halt pattern; dq_entry_t struct {insnbits, pc}.
- One sub-module: dq_ptr_ctl. It holds the head/tail/count registers and wrap logic, driven by enq/deq/flush strobes. The top holds storage and the state machine.

Test Plan:
- Reset then enqueue 3 words (PC 0x100, 0x104, 0x108) with in_stall=1 -> out_count=3, out_done=1, out_pc=0x100. Release stall -> PCs 0x100, 0x104, 0x108 on consecutive cycles, then out_empty=1.
- DEPTH=8: enqueue 8 with stall -> out_full=1, out_fetch_ready=0, a 9th in_fetch_done is ignored. Dequeue 1 and enqueue 1 in the same cycle for 20 cycles -> count stays at the expected value and pointers wrap with FIFO order preserved.
- Enqueue 5, assert in_flush with in_fetch_done=1 -> next cycle count=0, out_done=0, the flush-cycle word is not stored.
- Enqueue ADD, then HLT (0xD4400000) -> out_fetch_ready=0 after the HLT edge. Drain -> after the HLT dequeue, out_halted=1 and out_done stays 0 despite further in_fetch_done.
- Enqueue HLT, flush before dequeue -> state RUN, out_fetch_ready=1, out_halted=0.
- Assert in_rst_n=0 between clock edges with 4 entries queued -> out_count=0 and out_empty=1 immediately, before the next edge.
